// File: rtl/mulacc_u48_u24_8_if.sv
// Operand/result bundle for the iterative q*b+r multiply-accumulate.
// The master drives operands; the slave returns ready and the result.
interface mulacc_u48_u24_8_if;
  logic        vldin;
  logic        ready;
  logic [47:0] qin;
  logic [23:0] bin;
  logic [22:0] rin;
  logic        vldout;
  logic [47:0] out;
  logic        ovf;

  modport master (
    output vldin, qin, bin, rin,
    input  ready, vldout, out, ovf
  );

  modport slave (
    input  vldin, qin, bin, rin,
    output ready, vldout, out, ovf
  );
endinterface

// File: rtl/mulacc_u48_u24_8.sv
// Iterative unsigned out = q*b + r, scanning b three bits per cycle.
// Inverse path of divi_u48_u24_8; one operation in flight at a time.
module mulacc_u48_u24_8 (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  mulacc_u48_u24_8_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [71:0] q_sh;
  logic [23:0] b_sh;
  logic [71:0] acc;
  logic [2:0]  cnt;
  logic [71:0] pp;
  logic [71:0] acc_nxt;

  // x0..x7 partial product from shifted copies of q_sh
  always_comb begin
    pp = '0;
    if (b_sh[0]) pp = pp + q_sh;
    if (b_sh[1]) pp = pp + (q_sh << 1);
    if (b_sh[2]) pp = pp + (q_sh << 2);
    acc_nxt = acc + pp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      q_sh       <= '0;
      b_sh       <= '0;
      acc        <= '0;
      cnt        <= '0;
      bus.ready  <= 1'b1;
      bus.vldout <= 1'b0;
      bus.out    <= '0;
      bus.ovf    <= 1'b0;
    end else if (en) begin
      bus.vldout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.vldin) begin
            q_sh      <= {24'd0, bus.qin};
            b_sh      <= bus.bin;
            acc       <= {49'd0, bus.rin};
            cnt       <= '0;
            state     <= RUN;
            bus.ready <= 1'b0;
          end
        end
        RUN: begin
          acc  <= acc_nxt;
          q_sh <= q_sh << 3;
          b_sh <= b_sh >> 3;
          cnt  <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            bus.out    <= acc_nxt[47:0];
            bus.ovf    <= |acc_nxt[71:48];
            bus.vldout <= 1'b1;
            bus.ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mulacc_u48_u24_8.sv
// Self-checking bench for mulacc_u48_u24_8: cycle model plus
// hand-computed literal results for the directed cases.
module tb_mulacc_u48_u24_8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;

  mulacc_u48_u24_8_if bus ();

  mulacc_u48_u24_8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Behavioural model: exact arithmetic, timing counted in en edges
  bit          m_ready = 1'b1;
  bit          m_vld = 1'b0;
  logic [47:0] m_out = '0;
  bit          m_ovf = 1'b0;
  int          m_left = 0;
  logic [47:0] p_out;
  bit          p_ovf;
  logic [95:0] full;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready = 1'b1;
      m_vld   = 1'b0;
      m_out   = '0;
      m_ovf   = 1'b0;
      m_left  = 0;
    end else if (en) begin
      m_vld = 1'b0;
      if (m_ready && bus.vldin) begin
        full = 96'(bus.qin) * 96'(bus.bin) + 96'(bus.rin);
        p_out = full[47:0];
        p_ovf = |full[95:48];
        m_ready = 1'b0;
        m_left = 8;
      end else if (!m_ready) begin
        m_left--;
        if (m_left == 0) begin
          m_out   = p_out;
          m_ovf   = p_ovf;
          m_vld   = 1'b1;
          m_ready = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("ready", 64'(bus.ready), 64'(m_ready));
    chk("vldout", 64'(bus.vldout), 64'(m_vld));
    chk("out", 64'(bus.out), 64'(m_out));
    chk("ovf", 64'(bus.ovf), 64'(m_ovf));
  end

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!bus.ready && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, "_rdy_timeout"}, 64'(bus.ready), 64'd1);
  endtask

  // Issue one op at the next edge and wait for its strobe
  task automatic run_op(input logic [47:0] q, input logic [23:0] b,
                        input logic [22:0] r, input logic [47:0] eo,
                        input bit eov, input string nm,
                        input bit drop, output int lowcnt);
    int n = 0;
    wait_ready(nm);
    bus.vldin = 1'b1;
    bus.qin = q;
    bus.bin = b;
    bus.rin = r;
    @(posedge clk);
    #1;
    bus.vldin = 1'b0;
    bus.qin = $urandom;
    lowcnt = 0;
    if (drop) begin
      @(posedge clk);
      @(posedge clk);
      #1;
      bus.vldin = 1'b1;
      bus.bin = 24'h5a5a5a;
      @(posedge clk);
      #1;
      bus.vldin = 1'b0;
      lowcnt = 3;
    end
    forever begin
      @(negedge clk);
      if (bus.vldout || n > 30) break;
      if (!bus.ready) lowcnt++;
      n++;
    end
    chk({nm, "_vld"}, 64'(bus.vldout), 64'd1);
    chk({nm, "_out"}, 64'(bus.out), 64'(eo));
    chk({nm, "_ovf"}, 64'(bus.ovf), 64'(eov));
  endtask

  logic [47:0] a_r;
  logic [47:0] q_r;
  logic [23:0] b_r;
  logic [47:0] r_r;
  logic [47:0] held;
  int lc;
  int edges;

  initial begin
    bus.vldin = 1'b0;
    bus.qin = '0;
    bus.bin = '0;
    bus.rin = '0;
    #12;
    chk("rst_ready", 64'(bus.ready), 64'd1);
    chk("rst_vldout", 64'(bus.vldout), 64'd0);
    chk("rst_out", 64'(bus.out), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    en = 1'b1;

    run_op(48'd100, 24'd7, 23'd3, 48'h0000000002BF, 1'b0,
           "basic", 1'b0, lc);
    chk("basic_ready_low", 64'(lc), 64'd8);
    run_op(48'hFFFFFFFFFFFF, 24'hFFFFFF, 23'd0, 48'hFFFFFF000001,
           1'b1, "ovf", 1'b0, lc);
    run_op(48'hABCDEF012345, 24'd0, 23'h7FFFFF, 48'h0000007FFFFF,
           1'b0, "zero_b", 1'b0, lc);
    run_op(48'd1000, 24'd3, 23'd5, 48'd3005, 1'b0, "busy_drop",
           1'b1, lc);

    a_r = 48'h123456789ABC;
    b_r = 24'h00ABCD;
    q_r = a_r / 48'(b_r);
    r_r = a_r % 48'(b_r);
    run_op(q_r, b_r, r_r[22:0], 48'h123456789ABC, 1'b0, "rtrip0",
           1'b0, lc);

    // Stall: en low for 5 edges in the middle of RUN
    wait_ready("stall");
    bus.vldin = 1'b1;
    bus.qin = 48'd12345;
    bus.bin = 24'd100;
    bus.rin = 23'd6;
    @(posedge clk);
    #1;
    bus.vldin = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    en = 1'b1;
    edges = 7;
    repeat (20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (bus.vldout) break;
    end
    chk("stall_edge", 64'(edges), 64'd13);
    chk("stall_out", 64'(bus.out), 64'd1234506);
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("stall_vld_hold", 64'(bus.vldout), 64'd1);
    en = 1'b1;

    // Reset in the middle of an operation
    wait_ready("rst_mid");
    @(posedge clk);
    #1;
    bus.vldin = 1'b1;
    bus.qin = 48'd777;
    bus.bin = 24'd9;
    bus.rin = 23'd1;
    @(posedge clk);
    #1;
    bus.vldin = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_ready", 64'(bus.ready), 64'd1);
    chk("rstmid_vldout", 64'(bus.vldout), 64'd0);
    chk("rstmid_out", 64'(bus.out), 64'd0);
    chk("rstmid_ovf", 64'(bus.ovf), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_op(48'd50, 24'd20, 23'd9, 48'd1009, 1'b0, "after_rst",
           1'b0, lc);
    chk("after_rst_ready_low", 64'(lc), 64'd8);

    // Random traffic: en gaps, vldin while busy, edge operands
    repeat (1500) begin
      @(posedge clk);
      #1;
      en = ($urandom % 8) != 0;
      bus.vldin = ($urandom % 3) == 0;
      bus.qin = {$urandom, $urandom};
      case ($urandom % 4)
        0: bus.bin = '0;
        1: bus.bin = 24'hFFFFFF;
        default: bus.bin = $urandom;
      endcase
      bus.rin = $urandom;
    end
    en = 1'b1;
    bus.vldin = 1'b0;

    // Round trips through an ideal divider
    repeat (1000) begin
      a_r = {$urandom, $urandom};
      b_r = 24'($urandom_range(1, 24'h7FFFFF));
      q_r = a_r / 48'(b_r);
      r_r = a_r % 48'(b_r);
      run_op(q_r, b_r, r_r[22:0], a_r, 1'b0, "rtrip", 1'b0, lc);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
